ram_bist: RTL and testbench
===========================

# ram_bist

Built-in self-test controller that drives the synchronous single-port RAM (`sync_ram`) as its initiator. On a `start` pulse it sweeps every address with a data pattern, reads it back, and repeats with the inverted pattern. It reports pass/fail and captures the first failing location. It sits between the RAM and test/control logic, owning the RAM's `we`/`re`/`addr`/`data_in` and observing `data_out`.

## Interface
Parameters:
- `DATA_WIDTH`, 8: RAM word width.
- `ADDR_WIDTH`, 4: RAM address width; DEPTH = 2**ADDR_WIDTH.
- `PATTERN`, 8'hA5: base pattern, DATA_WIDTH bits.

Ports:
- `clk`  in  1: single clock; all state on rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `start`  in  1: one-cycle request; sampled only in IDLE.
- `busy`  out  1: high from cycle after accepted `start` through the last RD1 cycle.
- `done`  out  1: one-cycle pulse at test end (pass or fail).
- `pass`  out  1: result of last completed test; valid when `done`, held until next accepted `start`.
- `fail_addr`  out  ADDR_WIDTH: address of first miscompare.
- `fail_data`  out  DATA_WIDTH: data read at first miscompare.
- `ram_we`  out  1: RAM write enable.
- `ram_re`  out  1: RAM read enable.
- `ram_addr`  out  ADDR_WIDTH: RAM address.
- `ram_wdata`  out  DATA_WIDTH: RAM write data.
- `ram_rdata`  in  DATA_WIDTH: RAM read data; registered by the RAM on the edge where `ram_re`=1, valid the following cycle.

## Operation
- States: IDLE -> WR0 -> RD0 -> WR1 -> RD1 -> DONE -> IDLE.
- Expected word for address a: E0(a) = PATTERN ^ a, with a zero-extended to DATA_WIDTH, or truncated to its low DATA_WIDTH bits if wider. E1(a) = ~E0(a).
- IDLE: all RAM controls 0. `start`=1 moves to WR0 and clears `pass`, `fail_addr`, `fail_data`.
- WR0/WR1: `ram_we`=1 for DEPTH cycles, addresses 0..DEPTH-1 ascending, `ram_wdata`=E0/E1. Address wraps to 0 on exit.
- RD0/RD1: `ram_re`=1 for DEPTH cycles, addresses ascending, followed by one drain cycle with `ram_re`=0. Each cycle compares `ram_rdata` against the expected word of the address issued in the previous cycle (expected value and address pipelined one stage).
- Miscompare: capture `fail_addr` and `fail_data`, drop RAM controls, and go to DONE with `pass`=0. No further RAM accesses occur.
- Completion of RD1 with no miscompare: DONE with `pass`=1.
- DONE: `done`=1 for one cycle, `busy`=0, then IDLE.
- `ram_we` and `ram_re` are never both 1.
- `start` outside IDLE (including the DONE cycle) is ignored and not queued.

## Timing
- Reset values: `busy`, `done`, `pass`, `ram_we`, `ram_re` = 0; `ram_addr`, `ram_wdata`, `fail_addr`, `fail_data` = 0; state IDLE.
- Reset mid-test aborts immediately, with no further writes.
- All outputs are registered.
- Edge E0 samples `start`; first write (addr 0) is driven in the cycle after E0.
- Full passing run: `busy` high for 2*(2*DEPTH+1) cycles (66 at DEPTH=16), then `done` in the next cycle.
- Miscompare detected in the compare cycle for address a: DONE is the next cycle.

## Test plan
Bench uses real `sync_ram`, DEPTH=16, PATTERN=8'hA5.
- Reset then `start` -> addr0 written A5, addr1 A4, addr15 AA; WR1 addr0 5A; `busy` 66 cycles; `done` pulse with `pass`=1.
- Fault wrapper forces stored bit0=0 at addr 5 -> RD0 passes (A0); RD1 expects 5F, reads 5E -> `fail_addr`=5, `fail_data`=5E, `pass`=0. No RAM access after the fault.
- `start` held high for 20 cycles mid-run -> exactly one run; total `busy` 66; single `done`.
- `rst_n` pulled low during WR1 at addr 7 -> all outputs 0 asynchronously. Release, then `start` -> full passing run.
- `start` asserted in the DONE cycle -> ignored, remains IDLE. `start` one cycle later -> new run, `pass` cleared at acceptance.
- Every cycle: assert `ram_we` & `ram_re` never both 1, and that `ram_addr` is ascending and contiguous within each phase.

Source files
------------

// File: rtl/ram_bist.sv
// ram_bist: built-in self-test controller for a synchronous single-port RAM.
// On an accepted start it writes every address with PATTERN ^ addr, reads it
// back, then repeats with the inverted word. The first miscompare ends the
// test immediately and its address and read data are captured.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start               one-cycle request, sampled only while idle
//   busy, done, pass    run status, end-of-test pulse, result of last test
//   fail_addr/fail_data first miscompare location and data
//   ram_we/ram_re/ram_addr/ram_wdata  RAM controls (all registered)
//   ram_rdata           RAM read data, valid the cycle after ram_re
module ram_bist #(
    parameter int                    DATA_WIDTH = 8,
    parameter int                    ADDR_WIDTH = 4,
    parameter logic [DATA_WIDTH-1:0] PATTERN    = 8'hA5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [ADDR_WIDTH-1:0] fail_addr,
    output logic [DATA_WIDTH-1:0] fail_data,
    output logic                  ram_we,
    output logic                  ram_re,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    input  logic [DATA_WIDTH-1:0] ram_rdata
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WR0  = 3'd1,
        S_RD0  = 3'd2,
        S_WR1  = 3'd3,
        S_RD1  = 3'd4,
        S_DONE = 3'd5
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = {ADDR_WIDTH{1'b1}};
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = {ADDR_WIDTH{1'b0}};
    localparam logic [DATA_WIDTH-1:0] DATA_ZERO = {DATA_WIDTH{1'b0}};

    // Expected word: address zero-extended (or truncated) to the data width,
    // XORed with the pattern, optionally inverted for the second pass.
    function automatic logic [DATA_WIDTH-1:0] exp_word(input logic [ADDR_WIDTH-1:0] a,
                                                       input logic                  inv);
        logic [DATA_WIDTH+ADDR_WIDTH-1:0] ext;
        logic [DATA_WIDTH-1:0]            w;
        ext = {{DATA_WIDTH{1'b0}}, a};
        w   = PATTERN ^ ext[DATA_WIDTH-1:0];
        if (inv) begin
            exp_word = ~w;
        end else begin
            exp_word = w;
        end
    endfunction

    state_t                state_q, state_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  pass_q, pass_d;
    logic [ADDR_WIDTH-1:0] fail_addr_q, fail_addr_d;
    logic [DATA_WIDTH-1:0] fail_data_q, fail_data_d;
    logic                  we_q, we_d;
    logic                  re_q, re_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    // Read pipeline: address issued last cycle, whose data arrives this cycle.
    logic                  cmp_valid_q, cmp_valid_d;
    logic [ADDR_WIDTH-1:0] cmp_addr_q, cmp_addr_d;
    logic                  miscmp_s;

    // Next-state and registered-output logic for the BIST sequencer.
    always_comb begin
        state_d     = state_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        pass_d      = pass_q;
        fail_addr_d = fail_addr_q;
        fail_data_d = fail_data_q;
        we_d        = 1'b0;
        re_d        = 1'b0;
        addr_d      = ADDR_ZERO;
        wdata_d     = DATA_ZERO;
        cmp_valid_d = re_q;
        cmp_addr_d  = addr_q;
        miscmp_s    = cmp_valid_q &&
                      (ram_rdata != exp_word(cmp_addr_q, (state_q == S_RD1)));

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d     = S_WR0;
                    busy_d      = 1'b1;
                    pass_d      = 1'b0;
                    fail_addr_d = ADDR_ZERO;
                    fail_data_d = DATA_ZERO;
                    we_d        = 1'b1;
                    wdata_d     = exp_word(ADDR_ZERO, 1'b0);
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WR0, S_WR1: begin
                if (addr_q == LAST_ADDR) begin
                    state_d = (state_q == S_WR0) ? S_RD0 : S_RD1;
                    re_d    = 1'b1;
                end else begin
                    we_d    = 1'b1;
                    addr_d  = addr_q + ADDR_ONE;
                    wdata_d = exp_word(addr_q + ADDR_ONE, (state_q == S_WR1));
                end
            end
            S_RD0, S_RD1: begin
                if (miscmp_s) begin
                    // Abort: controls already default to idle for the next cycle.
                    state_d     = S_DONE;
                    busy_d      = 1'b0;
                    done_d      = 1'b1;
                    pass_d      = 1'b0;
                    fail_addr_d = cmp_addr_q;
                    fail_data_d = ram_rdata;
                end else if (re_q) begin
                    if (addr_q == LAST_ADDR) begin
                        // Last read issued; next cycle is the drain compare.
                        re_d = 1'b0;
                    end else begin
                        re_d   = 1'b1;
                        addr_d = addr_q + ADDR_ONE;
                    end
                end else if (state_q == S_RD0) begin
                    state_d = S_WR1;
                    we_d    = 1'b1;
                    wdata_d = exp_word(ADDR_ZERO, 1'b1);
                end else begin
                    state_d = S_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            fail_addr_q <= ADDR_ZERO;
            fail_data_q <= DATA_ZERO;
            we_q        <= 1'b0;
            re_q        <= 1'b0;
            addr_q      <= ADDR_ZERO;
            wdata_q     <= DATA_ZERO;
            cmp_valid_q <= 1'b0;
            cmp_addr_q  <= ADDR_ZERO;
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            fail_addr_q <= fail_addr_d;
            fail_data_q <= fail_data_d;
            we_q        <= we_d;
            re_q        <= re_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cmp_valid_q <= cmp_valid_d;
            cmp_addr_q  <= cmp_addr_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign fail_addr = fail_addr_q;
    assign fail_data = fail_data_q;
    assign ram_we    = we_q;
    assign ram_re    = re_q;
    assign ram_addr  = addr_q;
    assign ram_wdata = wdata_q;

endmodule

// File: tb/tb_ram_bist.sv
// Directed bench for ram_bist with a behavioural sync RAM (DEPTH=16,
// PATTERN=8'hA5) and an optional stuck-at-0 fault on bit0 of address 5.
module tb_ram_bist;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       busy, done, pass;
    logic [3:0] fail_addr;
    logic [7:0] fail_data;
    logic       ram_we, ram_re;
    logic [3:0] ram_addr;
    logic [7:0] ram_wdata;
    logic [7:0] ram_rdata = 8'h00;

    ram_bist #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .PATTERN(8'hA5)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .busy(busy), .done(done), .pass(pass),
        .fail_addr(fail_addr), .fail_data(fail_data),
        .ram_we(ram_we), .ram_re(ram_re), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    // Synchronous RAM model with the fault wrapper on address 5.
    logic [7:0] mem [16];
    logic       fault_en = 1'b0;
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= (fault_en && ram_addr == 4'd5) ? (ram_wdata & 8'hFE) : ram_wdata;
        if (ram_re) ram_rdata <= mem[ram_addr];
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Per-cycle monitor: exclusive we/re and contiguous ascending addresses.
    logic       prev_we = 1'b0, prev_re = 1'b0;
    logic [3:0] prev_addr = 4'd0;
    int         busy_total = 0, done_total = 0;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_we <= 1'b0;
            prev_re <= 1'b0;
            prev_addr <= 4'd0;
        end else begin
            logic [3:0] nxt;
            nxt = prev_addr + 4'd1;
            if (busy) busy_total <= busy_total + 1;
            if (done) done_total <= done_total + 1;
            chk("we_re_exclusive", {31'd0, ram_we & ram_re}, 32'd0);
            if (ram_we) chk("wr_addr_seq", {28'd0, ram_addr}, prev_we ? {28'd0, nxt} : 32'd0);
            if (ram_re) chk("rd_addr_seq", {28'd0, ram_addr}, prev_re ? {28'd0, nxt} : 32'd0);
            prev_we <= ram_we;
            prev_re <= ram_re;
            prev_addr <= ram_addr;
        end
    end

    typedef struct {
        int         k;      // cycles after the accepting edge
        logic [4:0] ctl;    // {busy, done, pass, we, re}
        logic       chk_a;
        logic [3:0] addr;
        logic       chk_w;
        logic [7:0] wd;
    } vec_t;

    vec_t vecs [13];

    task automatic kick();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int max, output int k);
        k = 0;
        while (!done && k < max) begin
            @(negedge clk);
            k++;
        end
        chk("done_seen", {31'd0, done}, 32'd1);
    endtask

    initial begin
        int k;
        int n;
        int acc;

        vecs[0]  = '{0,  5'b10010, 1'b1, 4'd0,  1'b1, 8'hA5};
        vecs[1]  = '{1,  5'b10010, 1'b1, 4'd1,  1'b1, 8'hA4};
        vecs[2]  = '{15, 5'b10010, 1'b1, 4'd15, 1'b1, 8'hAA};
        vecs[3]  = '{16, 5'b10001, 1'b1, 4'd0,  1'b0, 8'h00};
        vecs[4]  = '{31, 5'b10001, 1'b1, 4'd15, 1'b0, 8'h00};
        vecs[5]  = '{32, 5'b10000, 1'b0, 4'd0,  1'b0, 8'h00};
        vecs[6]  = '{33, 5'b10010, 1'b1, 4'd0,  1'b1, 8'h5A};
        vecs[7]  = '{34, 5'b10010, 1'b1, 4'd1,  1'b1, 8'h5B};
        vecs[8]  = '{48, 5'b10010, 1'b1, 4'd15, 1'b1, 8'h55};
        vecs[9]  = '{49, 5'b10001, 1'b1, 4'd0,  1'b0, 8'h00};
        vecs[10] = '{65, 5'b10000, 1'b0, 4'd0,  1'b0, 8'h00};
        vecs[11] = '{66, 5'b01100, 1'b0, 4'd0,  1'b0, 8'h00};
        vecs[12] = '{67, 5'b00100, 1'b0, 4'd0,  1'b0, 8'h00};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_ctl", {27'd0, busy, done, pass, ram_we, ram_re}, 32'd0);
        chk("rst_addr", {28'd0, ram_addr}, 32'd0);
        chk("rst_wdata", {24'd0, ram_wdata}, 32'd0);
        chk("rst_fail", {20'd0, fail_addr, fail_data}, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Table-driven full passing run
        kick();
        k = 0;
        for (int i = 0; i < 13; i++) begin
            while (k < vecs[i].k) begin
                @(negedge clk);
                k++;
            end
            chk($sformatf("vec%0d_ctl", i), {27'd0, busy, done, pass, ram_we, ram_re}, {27'd0, vecs[i].ctl});
            if (vecs[i].chk_a) chk($sformatf("vec%0d_addr", i), {28'd0, ram_addr}, {28'd0, vecs[i].addr});
            if (vecs[i].chk_w) chk($sformatf("vec%0d_wdata", i), {24'd0, ram_wdata}, {24'd0, vecs[i].wd});
        end

        // start held high for 20 cycles: exactly one run
        repeat (2) @(negedge clk);
        busy_total = 0;
        done_total = 0;
        start = 1'b1;
        repeat (20) @(negedge clk);
        start = 1'b0;
        repeat (100) @(negedge clk);
        chk("held_busy_cycles", busy_total, 32'd66);
        chk("held_done_count", done_total, 32'd1);
        chk("held_pass", {31'd0, pass}, 32'd1);

        // Stuck bit0 at address 5: RD0 passes, RD1 fails at addr 5
        fault_en = 1'b1;
        kick();
        wait_done(100, k);
        chk("fault_done_cycle", k, 32'd56);
        chk("fault_pass", {31'd0, pass}, 32'd0);
        chk("fault_addr", {28'd0, fail_addr}, 32'd5);
        chk("fault_data", {24'd0, fail_data}, 32'h5E);
        chk("fault_done_ctl", {30'd0, ram_we, ram_re}, 32'd0);
        acc = 0;
        repeat (20) begin
            @(negedge clk);
            if (ram_we || ram_re) acc++;
        end
        chk("fault_no_access", acc, 32'd0);
        fault_en = 1'b0;

        // start during DONE ignored, one cycle later accepted
        kick();
        chk("fail_cleared", {20'd0, fail_addr, fail_data}, 32'd0);
        wait_done(100, k);
        chk("run_cycles", k, 32'd66);
        chk("run_pass", {31'd0, pass}, 32'd1);
        start = 1'b1;
        @(negedge clk);
        chk("done_start_ignored", {29'd0, busy, done, ram_we}, 32'd0);
        chk("pass_held_idle", {31'd0, pass}, 32'd1);
        @(negedge clk);
        start = 1'b0;
        chk("restart_busy_we", {30'd0, busy, ram_we}, 32'd3);
        chk("restart_pass_cleared", {31'd0, pass}, 32'd0);
        wait_done(100, k);
        chk("restart_cycles", k, 32'd66);
        chk("restart_pass", {31'd0, pass}, 32'd1);

        // Reset during WR1 at address 7
        repeat (2) @(negedge clk);
        kick();
        n = 0;
        while (!(ram_we && ram_addr == 4'd7 && ram_wdata == 8'h5D) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("wr1_a7_cycle", n, 32'd40);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_ctl", {27'd0, busy, done, pass, ram_we, ram_re}, 32'd0);
        chk("abort_addr_wdata", {20'd0, ram_addr, ram_wdata}, 32'd0);
        chk("abort_fail", {20'd0, fail_addr, fail_data}, 32'd0);
        repeat (3) @(negedge clk);
        chk("abort_no_write", {24'd0, mem[8]}, 32'hAD);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        kick();
        wait_done(100, k);
        chk("post_reset_cycles", k, 32'd66);
        chk("post_reset_pass", {31'd0, pass}, 32'd1);
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
